// File: rtl/spi_rd_packer_if.sv
// Byte-in / word-out stream bundle for spi_rd_packer.
//   byte_vld/byte_data/byte_ready : beat stream from the SPI master read port
//   out_vld/out_data/out_keep/out_last/out_ready : packed word stream to host
// master : the packer (accepts beats, produces words)
// slave  : the surrounding environment (SPI master + host)
interface spi_rd_packer_if #(
  parameter int BYTE_W = 8,
  parameter int LANES  = 4
);
  logic                    byte_vld;
  logic [BYTE_W-1:0]       byte_data;
  logic                    byte_ready;
  logic                    out_vld;
  logic [BYTE_W*LANES-1:0] out_data;
  logic [LANES-1:0]        out_keep;
  logic                    out_last;
  logic                    out_ready;

  modport master (
    input  byte_vld, byte_data, out_ready,
    output byte_ready, out_vld, out_data, out_keep, out_last
  );

  modport slave (
    output byte_vld, byte_data, out_ready,
    input  byte_ready, out_vld, out_data, out_keep, out_last
  );
endinterface

// File: rtl/spi_rd_packer.sv
// Packs a request of start_len byte beats into LANES-wide words with
// keep/last flags, then pulses done once the last word is taken.
// Ports:
//   rd_clk, rd_rst_n    : clock, async active-low reset
//   start, start_len    : request launch (ignored while busy)
//   abort               : synchronous flush, highest priority
//   bus (master)        : beat input stream and word output stream
//   busy, done          : request in progress / completion pulse
//   word_cnt            : words emitted in the current or last request
module spi_rd_packer #(
  parameter int BYTE_W = 8,
  parameter int LANES  = 4,
  parameter int ENDIAN = 0
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst_n,
  input  logic                 start,
  input  logic [23:0]          start_len,
  input  logic                 abort,
  spi_rd_packer_if.master      bus,
  output logic                 busy,
  output logic                 done,
  output logic [21:0]          word_cnt
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t                       state;
  logic [23:0]                  remaining;
  logic [LW-1:0]                lane;
  logic [LW-1:0]                phys;
  logic [LANES-1:0][BYTE_W-1:0] acc;
  logic [LANES-1:0][BYTE_W-1:0] nxt_data;
  logic [LANES-1:0]             nxt_keep;
  logic [LANES-1:0][BYTE_W-1:0] odata;
  logic [LANES-1:0]             okeep;
  logic                         ovld, olast;
  logic                         ready, take, close;

  // Mid-word beats only touch the accumulator, so they may flow while the
  // output register is stalled; the closing beat needs the register free.
  assign ready = (state == COLLECT) &&
                 ((lane < LAST_LANE && remaining > 24'd1) || !ovld || bus.out_ready);
  assign take  = bus.byte_vld && ready;
  assign close = take && (lane == LAST_LANE || remaining == 24'd1);
  assign phys  = (ENDIAN != 0) ? LAST_LANE - lane : lane;

  // Closing word: earlier lanes from the accumulator, current lane from the
  // live beat, lanes past it zeroed (stale accumulator contents masked off).
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int            P  = (ENDIAN != 0) ? LANES - 1 - i : i;
    localparam logic [LW-1:0] LI = LW'(i);
    assign nxt_data[P] = (LI == lane) ? bus.byte_data :
                         (LI <  lane) ? acc[P] : '0;
    assign nxt_keep[P] = (LI <= lane);
  end

  assign bus.byte_ready = ready;
  assign bus.out_vld    = ovld;
  assign bus.out_data   = odata;
  assign bus.out_keep   = okeep;
  assign bus.out_last   = olast;
  assign busy           = (state != IDLE);

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      lane      <= '0;
      acc       <= '0;
      ovld      <= 1'b0;
      odata     <= '0;
      okeep     <= '0;
      olast     <= 1'b0;
      done      <= 1'b0;
      word_cnt  <= '0;
    end else if (abort) begin
      state     <= IDLE;
      remaining <= '0;
      lane      <= '0;
      ovld      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ovld && bus.out_ready) ovld <= 1'b0;  // a load below overrides this
      case (state)
        IDLE: begin
          if (start) begin
            if (start_len != '0) begin
              remaining <= start_len;
              lane      <= '0;
              word_cnt  <= '0;
              state     <= COLLECT;
            end else begin
              done <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (take) begin
            acc[phys] <= bus.byte_data;
            remaining <= remaining - 24'd1;
            lane      <= lane + LW'(1);
            if (close) begin
              ovld     <= 1'b1;
              odata    <= nxt_data;
              okeep    <= nxt_keep;
              olast    <= (remaining == 24'd1);
              word_cnt <= word_cnt + 22'd1;
              lane     <= '0;
              if (remaining == 24'd1) state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (ovld && bus.out_ready && olast) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_rd_packer.sv
module tb_spi_rd_packer;
  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int ENDIAN = 0;
  localparam int WW     = BYTE_W * LANES;

  logic        rd_clk   = 1'b0;
  logic        rd_rst_n = 1'b1;
  logic        start    = 1'b0;
  logic        abort    = 1'b0;
  logic [23:0] start_len = '0;
  logic        busy, done;
  logic [21:0] word_cnt;

  spi_rd_packer_if #(.BYTE_W(BYTE_W), .LANES(LANES)) bus();

  spi_rd_packer #(.BYTE_W(BYTE_W), .LANES(LANES), .ENDIAN(ENDIAN)) dut (
    .rd_clk    (rd_clk),
    .rd_rst_n  (rd_rst_n),
    .start     (start),
    .start_len (start_len),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .word_cnt  (word_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [WW-1:0]    data;
    logic [LANES-1:0] keep;
    logic             last;
  } word_t;

  word_t             exp_q[$];
  logic [BYTE_W-1:0] beats[$];

  // Reference: chop the beat list into LANES-sized chunks; last chunk may be short.
  function automatic void build_model();
    exp_q.delete();
    for (int k = 0; k * LANES < beats.size(); k++) begin
      word_t w = '0;
      for (int j = 0; j < LANES && k * LANES + j < beats.size(); j++) begin
        int p = (ENDIAN != 0) ? LANES - 1 - j : j;
        w.data[p*BYTE_W +: BYTE_W] = beats[k*LANES + j];
        w.keep[p] = 1'b1;
      end
      w.last = ((k + 1) * LANES >= beats.size());
      exp_q.push_back(w);
    end
  endfunction

  task automatic run_req(input int len, input int vld_pct, input int rdy_pct,
                         input int stall_len, input bit fixed, input string tag);
    int    sent = 0, cyc = 0, nwords, stall_left, first_acc = -1, last_acc = -1;
    int    stalled_acc = 0;
    bit    seen_vld = 0, done_due = 0, finished = 0, stalling;
    word_t got, w;
    beats.delete();
    for (int i = 0; i < len; i++)
      beats.push_back(fixed ? BYTE_W'((i + 1) * 17) : BYTE_W'($urandom));
    build_model();
    nwords = exp_q.size();
    stall_left = stall_len;
    @(posedge rd_clk); #1;
    start = 1'b1; start_len = 24'(len);
    while (!finished && cyc < 2000) begin
      @(posedge rd_clk); #1;
      start = 1'b0;
      cyc++;
      bus.byte_vld  = ($urandom_range(99) < vld_pct);
      bus.byte_data = (sent < len) ? beats[sent] : BYTE_W'($urandom);
      if (bus.out_vld) seen_vld = 1;
      stalling = seen_vld && stall_left > 0;
      if (stalling) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = ($urandom_range(99) < rdy_pct);
      end
      @(negedge rd_clk);
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
        end
      end
      if (done_due) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          errors++; $display("FAIL %s done_pulse: got done=%b busy=%b want 1/0", tag, done, busy);
        end
        finished = 1;
      end else begin
        checks++;
        if (done !== 1'b0) begin
          errors++; $display("FAIL %s done_early: got %b want 0", tag, done);
        end
      end
      if (sent >= len) begin
        checks++;
        if (bus.byte_ready !== 1'b0) begin
          errors++; $display("FAIL %s extra_beat: byte_ready=%b want 0", tag, bus.byte_ready);
        end
      end
      if (bus.byte_vld && bus.byte_ready) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        if (stalling) stalled_acc++;
        sent++;
      end
      if (bus.out_vld && bus.out_ready) begin
        got.data = bus.out_data; got.keep = bus.out_keep; got.last = bus.out_last;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s unexpected_word: got %h", tag, got.data);
        end else begin
          w = exp_q.pop_front();
          if (got !== w) begin
            errors++;
            $display("FAIL %s word: got data=%h keep=%b last=%b want data=%h keep=%b last=%b",
                     tag, got.data, got.keep, got.last, w.data, w.keep, w.last);
          end
          if (w.last) done_due = 1;
        end
      end
    end
    bus.byte_vld = 1'b0; bus.out_ready = 1'b0;
    if (!finished) begin
      checks++; errors++; $display("FAIL %s timeout: no done after %0d cycles", tag, cyc);
    end
    checks++;
    if (word_cnt !== 22'(nwords)) begin
      errors++; $display("FAIL %s word_cnt: got %0d want %0d", tag, word_cnt, nwords);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s missing_words: got %0d left want 0", tag, exp_q.size());
    end
    if (fixed && stall_len > 0 && vld_pct == 100) begin
      checks++;
      if (stalled_acc != LANES - 1) begin
        errors++; $display("FAIL %s stall_accepts: got %0d want %0d", tag, stalled_acc, LANES - 1);
      end
    end
    if (vld_pct == 100 && rdy_pct == 100 && stall_len == 0) begin
      checks++;
      if (first_acc != 1 || last_acc - first_acc != len - 1) begin
        errors++; $display("FAIL %s throughput: got first=%0d span=%0d want 1/%0d",
                           tag, first_acc, last_acc - first_acc, len - 1);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (bus.byte_ready !== 1'b0 || bus.out_vld !== 1'b0 || bus.out_data !== '0 ||
        bus.out_keep !== '0 || bus.out_last !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || word_cnt !== '0) begin
      errors++;
      $display("FAIL %s outputs: got rdy=%b vld=%b data=%h keep=%b last=%b busy=%b done=%b cnt=%0d want all 0",
               tag, bus.byte_ready, bus.out_vld, bus.out_data, bus.out_keep, bus.out_last,
               busy, done, word_cnt);
    end
  endtask

  task automatic test_reset();
    #1 rd_rst_n = 1'b0;
    #1 check_idle_outputs("reset");
    repeat (2) @(posedge rd_clk);
    @(negedge rd_clk); rd_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_req(8, 100, 100, 0, 1, "basic8");
  endtask

  task automatic test_short();
    run_req(5, 100, 100, 0, 1, "short5");
  endtask

  task automatic test_backpressure();
    run_req(12, 100, 100, 10, 1, "bp12");
  endtask

  task automatic test_zero_len();
    @(posedge rd_clk); #1; start = 1'b1; start_len = 24'd0;
    @(posedge rd_clk); #1; start = 1'b0;
    @(negedge rd_clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.out_vld !== 1'b0) begin
      errors++; $display("FAIL zero_len pulse: got done=%b busy=%b vld=%b want 1/0/0", done, busy, bus.out_vld);
    end
    repeat (3) begin
      @(negedge rd_clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || bus.out_vld !== 1'b0) begin
        errors++; $display("FAIL zero_len after: got done=%b busy=%b vld=%b want 0/0/0", done, busy, bus.out_vld);
      end
    end
  endtask

  task automatic test_abort();
    // six beats with host stalled: one word pending, two beats buffered
    @(posedge rd_clk); #1; start = 1'b1; start_len = 24'd8;
    for (int i = 0; i < 6; i++) begin
      @(posedge rd_clk); #1;
      start = 1'b0; bus.out_ready = 1'b0;
      bus.byte_vld = 1'b1; bus.byte_data = BYTE_W'($urandom);
    end
    @(posedge rd_clk); #1; bus.byte_vld = 1'b0; abort = 1'b1;
    @(posedge rd_clk); #1; abort = 1'b0;
    @(negedge rd_clk);
    checks++;
    if (bus.out_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.byte_ready !== 1'b0) begin
      errors++; $display("FAIL abort flush: got vld=%b busy=%b done=%b rdy=%b want 0/0/0/0",
                         bus.out_vld, busy, done, bus.byte_ready);
    end
    checks++;
    if (word_cnt !== 22'd1) begin
      errors++; $display("FAIL abort word_cnt: got %0d want 1", word_cnt);
    end
    repeat (2) begin
      @(negedge rd_clk);
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL abort no_done: got %b want 0", done);
      end
    end
    // start and abort together: abort wins
    @(posedge rd_clk); #1; start = 1'b1; abort = 1'b1; start_len = 24'd4;
    @(posedge rd_clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge rd_clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL start_abort: got busy=%b done=%b want 0/0", busy, done);
    end
    run_req(4, 100, 100, 0, 0, "after_abort4");
  endtask

  task automatic test_async_reset();
    @(posedge rd_clk); #1; start = 1'b1; start_len = 24'd8;
    for (int i = 0; i < 5; i++) begin
      @(posedge rd_clk); #1;
      start = 1'b0; bus.out_ready = 1'b0;
      bus.byte_vld = 1'b1; bus.byte_data = BYTE_W'($urandom);
    end
    @(posedge rd_clk); #1; bus.byte_vld = 1'b0;
    checks++;
    if (bus.out_vld !== 1'b1) begin
      errors++; $display("FAIL async_rst precond: out_vld=%b want 1", bus.out_vld);
    end
    #1 rd_rst_n = 1'b0;
    #1 check_idle_outputs("async_rst");
    @(negedge rd_clk); rd_rst_n = 1'b1;
    @(negedge rd_clk);
    checks++;
    if (busy !== 1'b0 || bus.byte_ready !== 1'b0) begin
      errors++; $display("FAIL async_rst idle: got busy=%b rdy=%b want 0/0", busy, bus.byte_ready);
    end
    run_req(4, 100, 100, 0, 1, "after_rst4");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++)
      run_req($urandom_range(20, 1), $urandom_range(100, 40), $urandom_range(100, 40),
              ($urandom_range(1, 0) != 0) ? $urandom_range(6, 0) : 0, 0, "rand");
  endtask

  initial begin
    bus.byte_vld = 1'b0; bus.byte_data = '0; bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_short();
    test_backpressure();
    test_zero_len();
    test_abort();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
